muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the execute stage. It accepts MULT/MULTU/DIV/DIVU requests and runs a 32-step iterative shift-add multiplier or restoring divider. It holds the front of the pipeline with `exe_stall` until the result is ready, then presents the 64-bit {HI,LO} value on `hilo_out`, which feeds the EX/MEM segment register.

---
 rtl/muldiv_ctrl.sv | 149 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: 32-step shift-add multiplier and
// restoring divider, holding the pipeline front with exe_stall until {HI,LO} is ready.
module muldiv_ctrl #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        exe_stall,
   output logic        busy,
   output logic        done,
   output logic [63:0] hilo_out,
   output logic        div_by_zero
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t        state, state_nxt;
   logic          accept;

   logic [CW-1:0] cnt;
   logic          is_div;
   logic          neg_res;
   logic          neg_rem;
   logic          dz;
   logic [31:0]   a_raw;
   logic [31:0]   opnd;
   logic [63:0]   acc;
   logic [32:0]   rem;

   logic          is_signed, a_neg, b_neg;
   logic [31:0]   mag_a, mag_b;
   logic [32:0]   mul_sum;
   logic [33:0]   diff;
   logic          q_bit;
   logic [32:0]   rem_nxt;
   logic [31:0]   quo_fix, rem_fix;
   logic [63:0]   result;

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      exe_stall = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            exe_stall = start;
            if (start && !flush) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            exe_stall = 1'b1;
            busy      = 1'b1;
            if (cnt == CW'(ITER - 1)) state_nxt = FIX;
         end
         FIX: begin
            exe_stall = 1'b1;
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Operands are stored as magnitudes; signs are reapplied in FIX.
   always_comb begin
      is_signed = !op[0];
      a_neg     = is_signed & src_a[31];
      b_neg     = is_signed & src_b[31];
      mag_a     = a_neg ? -src_a : src_a;
      mag_b     = b_neg ? -src_b : src_b;
   end

   // acc[31:0] holds the multiplier (mul) or the dividend shifting into quotient (div).
   always_comb begin
      mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      diff    = {rem, acc[31]} - {2'b00, opnd};
      q_bit   = !diff[33];
      rem_nxt = q_bit ? diff[32:0] : {rem[31:0], acc[31]};
   end

   always_comb begin
      quo_fix = neg_res ? -acc[31:0] : acc[31:0];
      rem_fix = neg_rem ? -rem[31:0] : rem[31:0];
      if (!is_div)  result = neg_res ? -acc : acc;
      else if (dz)  result = {a_raw, 32'hFFFF_FFFF};
      else          result = {rem_fix, quo_fix};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt         <= '0;
         is_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         dz          <= 1'b0;
         a_raw       <= '0;
         opnd        <= '0;
         acc         <= '0;
         rem         <= '0;
         hilo_out    <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= op[1] & a_neg;
            dz      <= op[1] & (src_b == 32'd0);
            a_raw   <= src_a;
            opnd    <= op[1] ? mag_b : mag_a;
            acc     <= {32'd0, op[1] ? mag_a : mag_b};
            rem     <= '0;
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
               acc[31:0] <= {acc[30:0], q_bit};
               rem       <= rem_nxt;
            end else begin
               acc <= {mul_sum, acc[31:1]};
            end
         end
         if (state == FIX && !flush) begin
            hilo_out    <= result;
            div_by_zero <= dz;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        resetn, start, flush;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        exe_stall, busy, done, div_by_zero;
   logic [63:0] hilo_out;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] prev_hilo;
   logic        prev_dz;

   muldiv_ctrl #(.ITER(32)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .flush       (flush),
      .exe_stall   (exe_stall),
      .busy        (busy),
      .done        (done),
      .hilo_out    (hilo_out),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [31:0]     q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (o == 2'd0) return sa * sb;
      if (o == 2'd1) return ua * ub;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (o == 2'd2) begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = 32'(ua / ub);
         r = 32'(ua % ub);
      end
      return {r, q};
   endfunction

   function automatic logic [63:0] ctl(input logic s, input logic bz, input logic d, input logic z);
      return {60'd0, s, bz, d, z};
   endfunction

   // Full 35-cycle transaction; start stays high through DONE like a real ID/EX register.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic exp_dz);
      @(posedge clk); #1;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      check("cyc0_ctl", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b1, 1'b0, 1'b0, prev_dz));
      for (int c = 1; c <= 34; c++) begin
         @(posedge clk); #1;
         op = 2'($urandom); src_a = $urandom; src_b = $urandom;
         @(negedge clk);
         if (c <= 33) begin
            check("calc_ctl", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b1, 1'b1, 1'b0, prev_dz));
            check("calc_hold", hilo_out, prev_hilo);
         end else begin
            check("done_ctl", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b0, 1'b0, 1'b1, exp_dz));
            check("done_hilo", hilo_out, exp);
         end
      end
      prev_hilo = exp;
      prev_dz   = exp_dz;
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check(tag, ctl(exe_stall, busy, done, div_by_zero), ctl(1'b0, 1'b0, 1'b0, prev_dz));
      check({tag, "_hilo"}, hilo_out, prev_hilo);
   endtask

   initial begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int          sel;

      resetn = 1'b0; start = 1'b0; flush = 1'b0;
      op = '0; src_a = '0; src_b = '0;
      prev_hilo = '0; prev_dz = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_ctl", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b0, 1'b0, 1'b0, 1'b0));
      check("rst_hilo", hilo_out, 64'h0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // Directed cases, chained back-to-back with start held through DONE.
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 1'b0);
      issue(2'd3, 32'd100,       32'd7,         64'h00000002_0000000E, 1'b0);
      issue(2'd0, 32'hFFFF_FFFE, 32'd3,         64'hFFFFFFFF_FFFFFFFA, 1'b0);
      issue(2'd0, 32'd7,         32'hFFFF_FFFF, 64'hFFFFFFFF_FFFFFFF9, 1'b0);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, 1'b0);
      issue(2'd2, 32'd5,         32'd0,         64'h00000005_FFFFFFFF, 1'b1);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);
      issue(2'd0, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 1'b0);
      issue(2'd3, 32'h1234_5678, 32'd0,         64'h12345678_FFFFFFFF, 1'b1);
      idle_cycle("gap_ctl");

      for (int n = 0; n < 30; n++) begin
         o   = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 5);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) b = $urandom_range(1, 9);
         else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         issue(o, a, b, model(o, a, b), o[1] && (b == 32'd0));
         for (int g = 0; g < $urandom_range(0, 2); g++) idle_cycle("rgap_ctl");
      end
      idle_cycle("pre_flush");

      // Flush in CALC at cycle 10: back to IDLE, no done, result untouched.
      @(posedge clk); #1;
      start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      check("fl_cyc0", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b1, 1'b0, 1'b0, prev_dz));
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 10) flush = 1'b1;
         @(negedge clk);
         check("fl_calc", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b1, 1'b1, 1'b0, prev_dz));
      end
      for (int c = 0; c < 40; c++) idle_cycle("fl_after");

      // Flush in IDLE blocks acceptance; stall still follows start.
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd4;
      @(negedge clk);
      check("ifl_stall", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b1, 1'b0, 1'b0, prev_dz));
      for (int c = 0; c < 3; c++) idle_cycle("ifl_block");

      // Reset in the middle of a DIV clears the result.
      @(posedge clk); #1;
      start = 1'b1; op = 2'd2; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         if (c == 15) resetn = 1'b0;
      end
      @(posedge clk); #1;
      resetn = 1'b1; start = 1'b0;
      @(negedge clk);
      check("rstmid_hilo", hilo_out, 64'h0);
      check("rstmid_ctl", ctl(exe_stall, busy, done, div_by_zero), ctl(1'b0, 1'b0, 1'b0, 1'b0));
      prev_hilo = '0;
      prev_dz   = 1'b0;
      issue(2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
      idle_cycle("end_ctl");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
